imem_responder: RTL and testbench

Instruction-memory responder that answers the fetch stage's read handshake (address, read strobe) with a registered 32-bit instruction word and a one-cycle valid pulse after a programmable number of wait states. It sits on the fetch-to-memory interface in place of the eventual cache. It holds a word-addressed instruction array that a boot loader fills through a separate write port. It aborts in-flight reads when the fetch address changes (branch redirect) or the read strobe drops.

---
 rtl/imem_responder_if.sv | 27 ++
 rtl/imem_responder.sv | 145 ++++++++++++++
 tb/tb_imem_responder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_responder_if.sv
// Fetch-to-memory read handshake bundle.
// The fetch stage drives address/strobe; the responder returns data, valid and error.
interface imem_responder_if #(
    parameter int BITSIZE = 32
);
    logic [BITSIZE-1:0] MEM_addr_i;
    logic               MEM_read_i;
    logic [31:0]        MEM_data_o;
    logic               MEM_valid_o;
    logic               MEM_err_o;

    modport master (
        output MEM_addr_i,
        output MEM_read_i,
        input  MEM_data_o,
        input  MEM_valid_o,
        input  MEM_err_o
    );

    modport slave (
        input  MEM_addr_i,
        input  MEM_read_i,
        output MEM_data_o,
        output MEM_valid_o,
        output MEM_err_o
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: word array with boot-load port and
// a wait-state read handshake that aborts on redirect or dropped strobe.
module imem_responder #(
    parameter int                 BITSIZE   = 32,
    parameter int                 DEPTH     = 1024,
    parameter int                 LATENCY   = 2,
    parameter logic [BITSIZE-1:0] BASE_ADDR = '0
) (
    input  logic               clk,
    input  logic               rst_i,
    imem_responder_if.slave    mem,
    input  logic               load_we_i,
    input  logic [BITSIZE-1:0] load_addr_i,
    input  logic [31:0]        load_data_i
);
    localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam logic [31:0] NOP   = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [BITSIZE-1:0] addr_q, addr_d;
    logic               capture;

    logic [31:0]        mem_q [DEPTH];

    logic [BITSIZE-1:0] rd_off, rd_word;
    logic [AW-1:0]      rd_idx;
    logic               rd_illegal;
    logic [BITSIZE-1:0] ld_off, ld_word;
    logic [AW-1:0]      ld_idx;
    logic               ld_ok;
    logic               collide;

    // Next-state logic; capture marks the edge that enters RESPOND.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem.MEM_read_i) begin
                    addr_d = mem.MEM_addr_i;
                    if (LATENCY == 0) begin
                        state_d = RESPOND;
                        capture = 1'b1;
                    end else begin
                        cnt_d   = LAT_M1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!mem.MEM_read_i) begin
                    state_d = IDLE;
                end else if (mem.MEM_addr_i != addr_q) begin
                    addr_d = mem.MEM_addr_i;
                    if (LATENCY == 1) begin
                        state_d = RESPOND;
                        capture = 1'b1;
                    end else begin
                        cnt_d = LAT_M1;
                    end
                end else if (cnt_q == 4'd0) begin
                    state_d = RESPOND;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Word index of the request being captured and its legality.
    always_comb begin
        rd_off     = addr_d - BASE_ADDR;
        rd_word    = rd_off >> 2;
        rd_idx     = rd_word[AW-1:0];
        rd_illegal = (addr_d[1:0] != 2'b00) || (rd_word >= BITSIZE'(DEPTH));
    end

    // Boot-load target word and same-word collision with a capture.
    always_comb begin
        ld_off  = load_addr_i - BASE_ADDR;
        ld_word = ld_off >> 2;
        ld_idx  = ld_word[AW-1:0];
        ld_ok   = ld_word < BITSIZE'(DEPTH);
        collide = load_we_i && ld_ok && (ld_idx == rd_idx);
    end

    // Handshake state, wait counter and latched request address.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    // Response registers; data changes only on the RESPOND-entry edge.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            mem.MEM_data_o  <= 32'd0;
            mem.MEM_valid_o <= 1'b0;
            mem.MEM_err_o   <= 1'b0;
        end else if (capture) begin
            mem.MEM_valid_o <= 1'b1;
            mem.MEM_err_o   <= rd_illegal;
            if (rd_illegal) begin
                mem.MEM_data_o <= NOP;
            end else if (collide) begin
                mem.MEM_data_o <= load_data_i;
            end else begin
                mem.MEM_data_o <= mem_q[rd_idx];
            end
        end else begin
            mem.MEM_valid_o <= 1'b0;
            mem.MEM_err_o   <= 1'b0;
        end
    end

    // Boot-load write port; out-of-range words are dropped, contents never reset.
    always_ff @(posedge clk) begin
        if (load_we_i && ld_ok) begin
            mem_q[ld_idx] <= load_data_i;
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder at LATENCY 0, 2 and 3 with a
// response scoreboard (data, error flag and arrival cycle).
module tb_imem_responder;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        read;
    logic        we;
    logic [31:0] la;
    logic [31:0] ld;
    int          sel;
    int          cyc;
    int          total;
    int          pass;
    int          fail;
    int          vcount;

    logic [31:0] pre [4] = '{32'h00500093, 32'h00100113, 32'h002081B3, 32'h00000013};

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          c;
    } exp_t;

    exp_t sb [$];

    imem_responder_if #(.BITSIZE(32)) if0 ();
    imem_responder_if #(.BITSIZE(32)) if2 ();
    imem_responder_if #(.BITSIZE(32)) if3 ();

    assign if0.MEM_addr_i = addr;
    assign if2.MEM_addr_i = addr;
    assign if3.MEM_addr_i = addr;
    assign if0.MEM_read_i = read && (sel == 0);
    assign if2.MEM_read_i = read && (sel == 2);
    assign if3.MEM_read_i = read && (sel == 3);

    imem_responder #(.BITSIZE(32), .DEPTH(16), .LATENCY(0), .BASE_ADDR(32'h0)) u0 (
        .clk(clk), .rst_i(rst), .mem(if0),
        .load_we_i(we), .load_addr_i(la), .load_data_i(ld)
    );
    imem_responder #(.BITSIZE(32), .DEPTH(16), .LATENCY(2), .BASE_ADDR(32'h0)) u2 (
        .clk(clk), .rst_i(rst), .mem(if2),
        .load_we_i(we), .load_addr_i(la), .load_data_i(ld)
    );
    imem_responder #(.BITSIZE(32), .DEPTH(16), .LATENCY(3), .BASE_ADDR(32'h0)) u3 (
        .clk(clk), .rst_i(rst), .mem(if3),
        .load_we_i(we), .load_addr_i(la), .load_data_i(ld)
    );

    logic        v_s;
    logic        e_s;
    logic [31:0] d_s;

    assign v_s = (sel == 0) ? if0.MEM_valid_o : (sel == 2) ? if2.MEM_valid_o : if3.MEM_valid_o;
    assign e_s = (sel == 0) ? if0.MEM_err_o   : (sel == 2) ? if2.MEM_err_o   : if3.MEM_err_o;
    assign d_s = (sel == 0) ? if0.MEM_data_o  : (sel == 2) ? if2.MEM_data_o  : if3.MEM_data_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass++;
        else begin
            fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every observed valid must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && v_s) begin
            vcount++;
            chk("unexpected_valid", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t x;
                x = sb.pop_front();
                chk("resp_data", d_s, x.d);
                chk("resp_err", 32'(e_s), 32'(x.e));
                chk("resp_cycle", 32'(cyc), 32'(x.c));
            end
        end
    end

    // Present a request at a negedge, wait for its valid, return one cycle later.
    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic e, input int lat);
        logic got;
        addr = a;
        read = 1'b1;
        sb.push_back('{d, e, cyc + 1 + lat});
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = v_s;
        end
        chk("fetch_timeout", 32'(got), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int v0;
        rst = 1'b1;
        read = 1'b0;
        addr = '0;
        we = 1'b0;
        la = '0;
        ld = '0;
        sel = 2;
        total = 0;
        pass = 0;
        fail = 0;
        vcount = 0;

        #1;
        chk("reset_valid", 32'(v_s), 32'd0);
        chk("reset_err", 32'(e_s), 32'd0);
        chk("reset_data", d_s, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            we = 1'b1;
            la = 32'(i * 4);
            ld = pre[i];
            @(negedge clk);
        end
        la = 32'd64;
        ld = 32'hFFFFFFFF;
        @(negedge clk);
        we = 1'b0;

        sel = 2;
        fetch(32'h4, pre[1], 1'b0, 2);
        read = 1'b0;
        repeat (3) @(negedge clk);
        chk("data_hold", d_s, pre[1]);
        chk("valid_low_after", 32'(v_s), 32'd0);

        fetch(32'h0, pre[0], 1'b0, 2);
        read = 1'b0;
        @(negedge clk);

        fetch(32'h2, NOP, 1'b1, 2);
        fetch(32'd64, NOP, 1'b1, 2);
        read = 1'b0;
        @(negedge clk);

        sel = 0;
        v0 = vcount;
        fetch(32'h0, pre[0], 1'b0, 0);
        fetch(32'h4, pre[1], 1'b0, 0);
        fetch(32'h8, pre[2], 1'b0, 0);
        read = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_count", 32'(vcount - v0), 32'd3);

        sel = 3;
        v0 = vcount;
        addr = 32'h0;
        read = 1'b1;
        @(negedge clk);
        addr = 32'hC;
        sb.push_back('{pre[3], 1'b0, cyc + 1 + 3});
        repeat (8) @(negedge clk);
        read = 1'b0;
        repeat (3) @(negedge clk);
        chk("redirect_count", 32'(vcount - v0), 32'd1);

        sel = 2;
        addr = 32'h4;
        read = 1'b1;
        sb.push_back('{32'hDEADBEEF, 1'b0, cyc + 1 + 2});
        @(negedge clk);
        @(negedge clk);
        we = 1'b1;
        la = 32'h4;
        ld = 32'hDEADBEEF;
        @(negedge clk);
        we = 1'b0;
        @(negedge clk);
        read = 1'b0;
        @(negedge clk);

        v0 = vcount;
        addr = 32'h8;
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_no_valid", 32'(vcount - v0), 32'd0);
        fetch(32'h8, pre[2], 1'b0, 2);
        read = 1'b0;
        @(negedge clk);

        addr = 32'h4;
        read = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_wait_valid", 32'(v_s), 32'd0);
        chk("rst_wait_err", 32'(e_s), 32'd0);
        chk("rst_wait_data", d_s, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        read = 1'b0;
        @(negedge clk);
        fetch(32'h4, 32'hDEADBEEF, 1'b0, 2);
        read = 1'b0;
        @(negedge clk);

        addr = 32'hC;
        read = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("respond_valid", 32'(v_s), 32'd1);
        chk("respond_data", d_s, pre[3]);
        #1 rst = 1'b1;
        #1;
        chk("rst_resp_valid", 32'(v_s), 32'd0);
        chk("rst_resp_err", 32'(e_s), 32'd0);
        chk("rst_resp_data", d_s, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        read = 1'b0;
        @(negedge clk);
        fetch(32'h8, pre[2], 1'b0, 2);
        read = 1'b0;
        @(negedge clk);
        fetch(32'h0, pre[0], 1'b0, 2);
        read = 1'b0;

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
